// File: rtl/fwd_pkg.sv
// fwd_pkg: shared definitions for the EX-stage forwarding/hazard control.
//   - Operand-source select codes driven to the EX forwarding muxes.
//   - In-flight destination tag format {valid, rd, wen, wide, load}.
//   - Default register-index width and the wide-result high register.
package fwd_pkg;

  localparam int unsigned DEFAULT_REG_W  = 4;
  localparam int unsigned DEFAULT_HI_REG = 15;

  localparam logic [2:0] SRC_OPDATA = 3'b000;  // register file data
  localparam logic [2:0] SRC_MEM_HI = 3'b001;  // MEM result [31:16]
  localparam logic [2:0] SRC_MEM_LO = 3'b010;  // MEM result [15:0]
  localparam logic [2:0] SRC_WB_HI  = 3'b011;  // WB result [31:16]
  localparam logic [2:0] SRC_WB_LO  = 3'b100;  // WB result [15:0]

  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_REG_W-1:0] rd;
    logic                     wen;
    logic                     wide;
    logic                     load;
  } fwdTag_t;

  localparam fwdTag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: combinational operand-source select for one ID source register.
// Ports:
//   src    - source register index read by the instruction in ID
//   used   - the source is actually read
//   exTag  - tag of the instruction now in EX (its result will sit in MEM)
//   memTag - tag of the instruction now in MEM (its result will sit in WB)
//   sel    - 3-bit select to register for the EX forwarding mux
// The tag rd field is sized by fwd_pkg::DEFAULT_REG_W; REG_W must match it.
module fwd_sel
  import fwd_pkg::*;
#(
  parameter int unsigned REG_W  = DEFAULT_REG_W,
  parameter int unsigned HI_REG = DEFAULT_HI_REG
) (
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  fwdTag_t          exTag,
  input  fwdTag_t          memTag,
  output logic [2:0]       sel
);

  localparam logic [REG_W-1:0] HI_IDX = REG_W'(HI_REG);

  // Newer producer (EX) is checked before older (MEM); within one producer
  // the rd match is checked before the implicit HI_REG write. Load data only
  // exists once the load reaches WB, so an EX-stage load never forwards.
  always_comb begin
    sel = SRC_OPDATA;
    if (used) begin
      if (exTag.valid && exTag.wen && !exTag.load && exTag.rd == src) begin
        sel = SRC_MEM_LO;
      end else if (exTag.valid && exTag.wide && src == HI_IDX) begin
        sel = SRC_MEM_HI;
      end else if (memTag.valid && memTag.wen && memTag.rd == src) begin
        sel = SRC_WB_LO;
      end else if (memTag.valid && memTag.wide && src == HI_IDX) begin
        sel = SRC_WB_HI;
      end
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: forwarding and load-use hazard control for the 16-bit
// five-stage pipeline.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   id_valid            - ID holds a real instruction
//   id_rs_a/_used       - source A index / source A is read
//   id_rs_b/_used       - source B index / source B is read
//   id_rd, id_wen       - destination index / destination is written
//   id_wide             - 32-bit result: lo to id_rd, hi to HI_REG
//   id_is_load          - load, data available in WB (lo half only)
//   flush               - kill the ID instruction
//   stall_id            - hold PC and IF/ID, bubble into EX (combinational)
//   src_a, src_b        - registered EX operand selects
//   perf_fwd_cnt        - (FWD_PERF_CNT_EN) instructions entering EX forwarded
//   perf_stall_cnt      - (FWD_PERF_CNT_EN) stall cycles
// Optional feature macro: FWD_PERF_CNT_EN adds saturating 16-bit counters.
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned REG_W  = DEFAULT_REG_W,
  parameter int unsigned HI_REG = DEFAULT_HI_REG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs_a,
  input  logic             id_rs_a_used,
  input  logic [REG_W-1:0] id_rs_b,
  input  logic             id_rs_b_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wen,
  input  logic             id_wide,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall_id,
  output logic [2:0]       src_a,
  output logic [2:0]       src_b
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [15:0]      perf_fwd_cnt,
  output logic [15:0]      perf_stall_cnt
`endif
);

  // No WB tag is held: the instruction in WB at ID time has written the
  // register file before its consumer reaches EX, so nothing would read it.
  fwdTag_t    exTag;
  fwdTag_t    memTag;
  fwdTag_t    idTag;
  logic [2:0] selA;
  logic [2:0] selB;
  logic       hazA;
  logic       hazB;
  logic       loadUse;
  logic       enterEx;

  fwd_sel #(.REG_W(REG_W), .HI_REG(HI_REG)) uSelA (
    .src    (id_rs_a),
    .used   (id_rs_a_used),
    .exTag  (exTag),
    .memTag (memTag),
    .sel    (selA)
  );

  fwd_sel #(.REG_W(REG_W), .HI_REG(HI_REG)) uSelB (
    .src    (id_rs_b),
    .used   (id_rs_b_used),
    .exTag  (exTag),
    .memTag (memTag),
    .sel    (selB)
  );

  always_comb begin
    idTag       = TAG_BUBBLE;
    idTag.valid = 1'b1;
    idTag.rd    = id_rd;
    idTag.wen   = id_wen;
    idTag.wide  = id_wide & ~id_is_load;
    idTag.load  = id_is_load;

    hazA    = id_rs_a_used && (exTag.rd == id_rs_a);
    hazB    = id_rs_b_used && (exTag.rd == id_rs_b);
    // Flush wins over a load-use hit; reset masks stale tags.
    loadUse = rst_n & id_valid & ~flush & exTag.valid & exTag.load & exTag.wen
              & (hazA | hazB);
    enterEx = id_valid & ~loadUse & ~flush;
  end

  assign stall_id = loadUse;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exTag  <= TAG_BUBBLE;
      memTag <= TAG_BUBBLE;
      src_a  <= SRC_OPDATA;
      src_b  <= SRC_OPDATA;
    end else begin
      memTag <= exTag;
      if (enterEx) begin
        exTag <= idTag;
        src_a <= selA;
        src_b <= selB;
      end else begin
        exTag <= TAG_BUBBLE;
        src_a <= SRC_OPDATA;
        src_b <= SRC_OPDATA;
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fwd_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (enterEx && (selA != SRC_OPDATA || selB != SRC_OPDATA) &&
          perf_fwd_cnt != '1) begin
        perf_fwd_cnt <= perf_fwd_cnt + 16'd1;
      end
      if (loadUse && perf_stall_cnt != '1) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed-vector bench for fwd_ctrl with an in-bench model of
// the in-flight instruction window and literal expectations per scenario.
// Define FWD_PERF_CNT_EN to also exercise the performance counters.
module tb_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_rs_a;
  logic       id_rs_a_used;
  logic [3:0] id_rs_b;
  logic       id_rs_b_used;
  logic [3:0] id_rd;
  logic       id_wen;
  logic       id_wide;
  logic       id_is_load;
  logic       flush;
  logic       stall_id;
  logic [2:0] src_a;
  logic [2:0] src_b;
`ifdef FWD_PERF_CNT_EN
  logic [15:0] perf_fwd_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fwd_ctrl #(.REG_W(4), .HI_REG(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs_a      (id_rs_a),
    .id_rs_a_used (id_rs_a_used),
    .id_rs_b      (id_rs_b),
    .id_rs_b_used (id_rs_b_used),
    .id_rd        (id_rd),
    .id_wen       (id_wen),
    .id_wide      (id_wide),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall_id     (stall_id),
    .src_a        (src_a),
    .src_b        (src_b)
`ifdef FWD_PERF_CNT_EN
    ,
    .perf_fwd_cnt   (perf_fwd_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model: window of the last two instructions issued to EX
  typedef struct packed {
    bit       valid;
    bit [3:0] rd;
    bit       wen;
    bit       wide;
    bit       load;
  } instr_t;

  instr_t    inFlight [2];   // [0] = most recent issue, [1] = the one before
  bit [2:0]  expA, expB;
  bit        live = 1'b0;
  bit [15:0] expFwdCnt, expStallCnt;
  bit        mStall;
  bit [2:0]  mA, mB;
  instr_t    mNew;

  // Producer at distance 0 will be in MEM, distance 1 in WB, when the
  // consumer is in EX. Load data is unreachable at distance 0.
  function automatic bit [2:0] expSel(input bit [3:0] s, input bit used);
    if (!used) return 3'd0;
    for (int d = 0; d < 2; d++) begin
      if (inFlight[d].valid) begin
        if (inFlight[d].wen && inFlight[d].rd == s && !(d == 0 && inFlight[d].load))
          return (d == 0) ? 3'd2 : 3'd4;
        if (inFlight[d].wide && s == 4'd15)
          return (d == 0) ? 3'd1 : 3'd3;
      end
    end
    return 3'd0;
  endfunction

  function automatic bit modelStall();
    return rst_n && id_valid && !flush && inFlight[0].valid && inFlight[0].load &&
           inFlight[0].wen &&
           ((id_rs_a_used && inFlight[0].rd == id_rs_a) ||
            (id_rs_b_used && inFlight[0].rd == id_rs_b));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      inFlight[0] = '0;
      inFlight[1] = '0;
      expA = 3'd0;
      expB = 3'd0;
      expFwdCnt = 16'd0;
      expStallCnt = 16'd0;
      live = 1'b1;
    end else if (live) begin
      mStall = modelStall();
      if (mStall && expStallCnt != 16'hFFFF) expStallCnt++;
      if (id_valid && !mStall && !flush) begin
        mA = expSel(id_rs_a, id_rs_a_used);
        mB = expSel(id_rs_b, id_rs_b_used);
        mNew = '{1'b1, id_rd, id_wen, id_wide && !id_is_load, id_is_load};
      end else begin
        mA = 3'd0;
        mB = 3'd0;
        mNew = '0;
      end
      if ((mA != 3'd0 || mB != 3'd0) && expFwdCnt != 16'hFFFF) expFwdCnt++;
      inFlight[1] = inFlight[0];
      inFlight[0] = mNew;
      expA = mA;
      expB = mB;
    end
  end

  // ---------------- compare process: every cycle once the model is live
  always @(negedge clk) begin
    if (live) begin
      chk("cmp_stall", {15'd0, stall_id}, {15'd0, modelStall()});
      chk("cmp_src_a", {13'd0, src_a}, {13'd0, expA});
      chk("cmp_src_b", {13'd0, src_b}, {13'd0, expB});
`ifdef FWD_PERF_CNT_EN
      chk("cmp_perf_fwd", perf_fwd_cnt, expFwdCnt);
      chk("cmp_perf_stall", perf_stall_cnt, expStallCnt);
`endif
    end
  end

  // ---------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [3:0] ra, input bit ua, input bit [3:0] rb,
                       input bit ub, input bit [3:0] rd, input bit wen, input bit wide,
                       input bit load, input bit fl);
    id_valid = v;  id_rs_a = ra; id_rs_a_used = ua; id_rs_b = rb; id_rs_b_used = ub;
    id_rd = rd;    id_wen = wen; id_wide = wide;    id_is_load = load; flush = fl;
  endtask

  task automatic idle(input int unsigned n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    // Reset held with a live self-dependent instruction in ID
    rst_n = 1'b0;
    drive(1, 3, 1, 3, 1, 3, 1, 0, 0, 0);
    tick(); tick();
    chk("rst_src_a", {13'd0, src_a}, 16'd0);
    chk("rst_src_b", {13'd0, src_b}, 16'd0);
    chk("rst_stall", {15'd0, stall_id}, 16'd0);
    rst_n = 1'b1;
    #1 chk("rel_stall", {15'd0, stall_id}, 16'd0);
    tick();
    chk("rel_src_a", {13'd0, src_a}, 16'd0);
    chk("rel_src_b", {13'd0, src_b}, 16'd0);
    idle(2);

    // Adjacent dependency
    drive(1, 1, 0, 2, 0, 3, 1, 0, 0, 0); tick();
    drive(1, 3, 1, 7, 0, 8, 0, 0, 0, 0); tick();
    chk("adj_src_a", {13'd0, src_a}, 16'd2);
    chk("adj_src_b", {13'd0, src_b}, 16'd0);
    idle(2);

    // Distance two
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
    idle(1);
    drive(1, 0, 1, 5, 1, 10, 0, 0, 0, 0); tick();
    chk("d2_src_b", {13'd0, src_b}, 16'd4);
    chk("d2_src_a", {13'd0, src_a}, 16'd0);
    idle(2);

    // Two writers of r6: newer wins
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0); tick();
    drive(1, 6, 1, 0, 0, 11, 0, 0, 0, 0); tick();
    chk("newer_src_a", {13'd0, src_a}, 16'd2);
    idle(2);

    // Wide producer, then two readers of r15 / r2
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); tick();
    drive(1, 15, 1, 2, 1, 12, 0, 0, 0, 0); tick();
    chk("wide1_src_a", {13'd0, src_a}, 16'd1);
    chk("wide1_src_b", {13'd0, src_b}, 16'd2);
    drive(1, 15, 1, 2, 1, 12, 0, 0, 0, 0); tick();
    chk("wide2_src_a", {13'd0, src_a}, 16'd3);
    chk("wide2_src_b", {13'd0, src_b}, 16'd4);
    idle(2);

    // Wide producer with rd == HI_REG: rd wins
    drive(1, 0, 0, 0, 0, 15, 1, 1, 0, 0); tick();
    drive(1, 15, 1, 0, 0, 12, 0, 0, 0, 0); tick();
    chk("hirdr_src_a", {13'd0, src_a}, 16'd2);
    idle(2);

    // Load-use: one stall cycle, bubble, then WB forwarding
    drive(1, 0, 0, 0, 0, 4, 1, 0, 1, 0); tick();
    drive(1, 4, 1, 1, 1, 9, 1, 0, 0, 0);
    #1 chk("lu_stall", {15'd0, stall_id}, 16'd1);
    tick();
    chk("lu_bubble_a", {13'd0, src_a}, 16'd0);
    chk("lu_stall_end", {15'd0, stall_id}, 16'd0);
    tick();
    chk("lu_src_a", {13'd0, src_a}, 16'd4);
    chk("lu_src_b", {13'd0, src_b}, 16'd0);
    idle(2);

    // Load flagged wide: the high half is never forwarded
    drive(1, 0, 0, 0, 0, 4, 1, 1, 1, 0); tick();
    idle(1);
    drive(1, 15, 1, 4, 1, 12, 0, 0, 0, 0); tick();
    chk("wload_src_a", {13'd0, src_a}, 16'd0);
    chk("wload_src_b", {13'd0, src_b}, 16'd4);
    idle(2);

    // Flush with a load-use hit: no stall, bubble into EX
    drive(1, 0, 0, 0, 0, 4, 1, 0, 1, 0); tick();
    drive(1, 4, 1, 0, 0, 9, 1, 0, 0, 1);
    #1 chk("fl_stall", {15'd0, stall_id}, 16'd0);
    tick();
    chk("fl_src_a", {13'd0, src_a}, 16'd0);
    drive(1, 4, 1, 0, 0, 9, 1, 0, 0, 0);
    #1 chk("fl_stall2", {15'd0, stall_id}, 16'd0);
    tick();
    chk("fl_src_a2", {13'd0, src_a}, 16'd4);
    idle(2);

`ifdef FWD_PERF_CNT_EN
    chk("perf_stall_lit", perf_stall_cnt, 16'd1);
    chk("perf_fwd_lit", perf_fwd_cnt, 16'd9);
`endif

    // Reset mid-operation drops the in-flight producer
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    drive(1, 3, 1, 3, 1, 13, 0, 0, 0, 0); tick();
    chk("mrst_src_a", {13'd0, src_a}, 16'd0);
    chk("mrst_src_b", {13'd0, src_b}, 16'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
Name: fwd_ctrl

Overview:
- Forwarding and hazard control for the 16-bit five-stage pipeline (IF/ID/EX/MEM/WB).
- Generates the registered 3-bit operand-source selects that drive the EX-stage operand forwarding muxes, one select per operand.
- Tracks the destination tags of in-flight instructions in EX, MEM and WB.
- Detects load-use hazards and stalls ID for one cycle, inserting a bubble into EX.

Parameters:
- REG_W, 4, register index width (16 architectural registers).
- HI_REG, 15, register written with bits [31:16] of a wide (32-bit result) instruction.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs_a  in  REG_W  source A index.
- id_rs_a_used  in  1  source A is read.
- id_rs_b  in  REG_W  source B index.
- id_rs_b_used  in  1  source B is read.
- id_rd  in  REG_W  destination index.
- id_wen  in  1  instruction writes id_rd.
- id_wide  in  1  32-bit result: lo half to id_rd, hi half to HI_REG.
- id_is_load  in  1  load; data is available only in WB, lo half.
- flush  in  1  kill the ID instruction (taken branch).
- stall_id  out  1  hold PC and IF/ID; bubble into EX.
- src_a  out  3  operand A select, valid while the instruction is in EX.
- src_b  out  3  operand B select, same timing.

Behaviour:
- Clock and reset: all state changes on posedge clk. While rst_n=0: ex/mem/wb tags invalid, src_a=src_b=3'b000, stall_id=0.
- Reset mid-operation: all in-flight tags are dropped; no forwarding occurs after reset.
- Select encoding:
  - 000 register file data.
  - 001 MEM result [31:16].
  - 010 MEM result [15:0].
  - 011 WB result [31:16].
  - 100 WB result [15:0].
  - Codes 101–111 are never driven.
- Tag format: {valid, rd, wen, wide, load}. id_is_load forces wide=0.
- Each cycle (rst_n=1): wb <= mem; mem <= ex.
  - If id_valid & ~stall_id & ~flush: ex <= ID fields, and src_a/src_b <= computed selects.
  - Otherwise: ex <= bubble (invalid), src_a/src_b <= 000.
- Select computation, per used source S, against the current ex tag (moves to MEM) and current mem tag (moves to WB):
  - Ex tag valid, wen, rd==S → 010.
  - Else ex tag wide and HI_REG==S → 001.
  - Else mem tag valid, wen, rd==S → 100.
  - Else mem tag wide and HI_REG==S → 011.
  - Else → 000.
  - Unused source → 000.
  - Newer instruction (MEM) beats older (WB).
  - Within one wide instruction, rd beats HI_REG when rd==HI_REG.
- Load-use stall: stall_id=1 (combinational) when id_valid & ~flush & ex tag valid & load & wen & rd matches a used source.
  - The next cycle's ex tag is the bubble, so the stall lasts exactly 1 cycle.
  - The dependent instruction then selects 100.
- Loads never produce 010 or 001.
- Flush together with a stall condition: flush wins, stall_id=0, bubble into EX.
- Latency: selects are registered one cycle after ID; stall_id has zero latency.

Optional Feature:
- Macro FWD_PERF_CNT_EN.
- When defined: adds outputs perf_fwd_cnt[15:0] and perf_stall_cnt[15:0].
  - perf_fwd_cnt increments once per cycle in which a valid instruction enters EX with any non-000 select.
  - perf_stall_cnt increments once per stall_id cycle.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg:
  - Select constants SRC_OPDATA, SRC_MEM_HI, SRC_MEM_LO, SRC_WB_HI, SRC_WB_LO.
  - Tag struct typedef.
  - Default REG_W and HI_REG.
- Sub-module fwd_sel: combinational compare of one source against the ex and mem tags, producing a 3-bit select. Instantiated twice (A, B).

Test Plan:
- Reset: rst_n=0 for 2 cycles with id_valid=1, rs_a=rd=3 → src_a=src_b=000, stall_id=0; the cycle after release shows no forwarding.
- Adjacent dependency: add rd=3, next instruction rs_a=3 → in EX, src_a=010; src_b=000 (rs_b=7, unused writes).
- Distance two: add rd=5, nop, then rs_b=5 → src_b=100. Two adds rd=6 followed by a reader of 6 → 010 (newer wins).
- Wide: mul rd=2, next instruction rs_a=15, rs_b=2 → src_a=001, src_b=010. One instruction later → src_a=011, src_b=100.
- Load-use: load rd=4, next rs_a=4 → stall_id=1 for exactly one cycle, EX bubble (src 000), then src_a=100, stall_id=0.
- Flush plus load-use condition: flush=1 → stall_id=0, EX gets a bubble. With FWD_PERF_CNT_EN, perf_stall_cnt unchanged and perf_fwd_cnt counts 1 per forwarding instruction above.
